sobel_host: RTL and testbench
=============================

SOBEL_HOST -- requirements
Module: sobel_host

Interface
REQ-001 Parameter READ_LATENCY, default 1: cycles from accepted read to valid m_rdata; legal 1..7.
REQ-002 Parameter RESULT_ADDR, default 3'b100: agent address of the Sobel 2x2 result word.
REQ-003 Ports, in order:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run one 4x4 tile.
- row0, row1, row2, row3  in  32 each  tile rows, pixel 0 in [31:24]; sampled when start is accepted.
- busy  out  1  high while a transaction is in progress.
- done  out  1  one-cycle pulse when result is valid.
- result  out  32  {out_p0, out_p1, out_p2, out_p3} from the agent.
- m_addr  out  3  Avalon-MM address.
- m_wdata  out  32  write data.
- m_byteenable  out  4  byte enables.
- m_cs  out  1  chip select.
- m_read  out  1  read strobe.
- m_write  out  1  write strobe.
- m_waitrequest  in  1  agent stall; tie low for agents without stall.
- m_rdata  in  32  read data.
- err  out  1  readback mismatch flag (SOBEL_HOST_READBACK_EN only; constant 0 otherwise).

Function
REQ-004 States: IDLE, WRITE, READ, RWAIT, DONE (plus VERIFY, VWAIT under REQ-019).
REQ-005 IDLE: start=1 latches row0..row3 into internal registers and moves to WRITE with row index 0; start is ignored in every other state.
REQ-006 WRITE: m_write=1, m_cs=1, m_byteenable=4'hF, m_addr=index, m_wdata=latched row[index]; all outputs registered.
REQ-007 A command is accepted at an edge where m_waitrequest=0; while m_waitrequest=1 the address, data and strobes are held unchanged.
REQ-008 After acceptance with index 3, go to READ; otherwise increment index and stay in WRITE. Writes are back-to-back, with no idle cycle between them.
REQ-009 READ: m_read=1, m_cs=1, m_addr=RESULT_ADDR, m_write=0; after acceptance go to RWAIT.
REQ-010 RWAIT: strobes low; a 3-bit counter counts READ_LATENCY edges after acceptance. At the final edge, result<=m_rdata and go to DONE.
REQ-011 DONE: done=1 for exactly one cycle, then IDLE; result holds its value until the next capture.
REQ-012 busy=1 in every state except IDLE.
REQ-013 m_read and m_write are never high together; m_cs=m_read|m_write.
REQ-014 Latency with m_waitrequest=0 and READ_LATENCY=1: start accepted at edge N; writes occupy cycles N+1..N+4; read at N+5; capture at the end of N+6; done high in N+7. Each stall cycle adds exactly one cycle.
REQ-015 Row registers are not modified while busy, so input changes mid-run have no effect.

Reset
REQ-016 rst=1 at an edge forces IDLE, index=0, counter=0, and busy=done=m_read=m_write=m_cs=0, m_addr=0, m_wdata=0, m_byteenable=0, result=0, err=0.
REQ-017 rst mid-transaction aborts at the next edge; no strobe is asserted in the following cycle, and no done is produced for the aborted run.
REQ-018 start coincident with rst is ignored.

Configuration
REQ-019 With SOBEL_HOST_READBACK_EN defined:
- after the 4 writes, read addresses 0..3 (VERIFY/VWAIT, same handshake and latency rules as READ/RWAIT) before reading RESULT_ADDR.
- any readback word differing from its latched row sets err=1 in the DONE cycle; err clears at the next accepted start.
- adds 4*(1+READ_LATENCY) cycles to REQ-014.
REQ-020 Without SOBEL_HOST_READBACK_EN: no VERIFY states, err tied 0, timing exactly as REQ-014.

Verification
REQ-021 Basic: rows 0x0000FFFF x4, agent returns 0x00FFFF00 at addr 4, no stalls -> writes addr 0..3 with 0x0000FFFF at N+1..N+4; read addr 4 at N+5; done at N+7; result=0x00FFFF00.
REQ-022 Stall: m_waitrequest=1 for 3 cycles on the addr-2 write -> addr/wdata held for 4 cycles; done at N+10; data intact.
REQ-023 Latency: READ_LATENCY=3, agent data 0xDEADBEEF -> result=0xDEADBEEF; done at N+9.
REQ-024 Abort: rst pulsed during the addr-1 write -> next cycle all strobes 0, busy 0, result 0; next start runs a full, correct sequence.
REQ-025 Busy start: start pulsed at N+3 with different rows -> ignored; the original rows are written and one done is produced.
REQ-026 Readback (macro on): agent corrupts the addr-1 readback to 0x0000FFFE -> err=1 in the DONE cycle; a clean rerun -> err=0.

Source files
------------

// File: rtl/sobel_host.sv
// Avalon-MM host: writes a 4x4 tile to a Sobel agent, reads the 2x2 result back; outputs registered.
// Optional SOBEL_HOST_READBACK_EN: rows are read back and compared before the result read.
module sobel_host #(
   parameter int unsigned READ_LATENCY = 1,
   parameter logic [2:0]  RESULT_ADDR  = 3'b100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] row0,
   input  logic [31:0] row1,
   input  logic [31:0] row2,
   input  logic [31:0] row3,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [2:0]  m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_byteenable,
   output logic        m_cs,
   output logic        m_read,
   output logic        m_write,
   input  logic        m_waitrequest,
   input  logic [31:0] m_rdata,
   output logic        err
);
   localparam logic [2:0] LAST_CNT = 3'(READ_LATENCY - 1);

`ifdef SOBEL_HOST_READBACK_EN
   typedef enum logic [2:0] {IDLE, WRITE, READ, RWAIT, DONE, VERIFY, VWAIT} state_t;
`else
   typedef enum logic [2:0] {IDLE, WRITE, READ, RWAIT, DONE} state_t;
`endif

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] row_q [4];
   logic        accept_start, lat_done;
   logic        wr_d, rd_d;
   logic [2:0]  addr_d;
   logic [31:0] wdata_d;

   assign accept_start = (state_q == IDLE) && start;
   assign lat_done     = (cnt_q == LAST_CNT);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = WRITE;
               idx_d   = 2'd0;
            end
         end
         WRITE: begin
            if (!m_waitrequest) begin
               if (idx_q == 2'd3) begin
`ifdef SOBEL_HOST_READBACK_EN
                  state_d = VERIFY;
                  idx_d   = 2'd0;
`else
                  state_d = READ;
`endif
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
`ifdef SOBEL_HOST_READBACK_EN
         VERIFY: begin
            if (!m_waitrequest) begin
               state_d = VWAIT;
               cnt_d   = 3'd0;
            end
         end
         VWAIT: begin
            if (lat_done) begin
               cnt_d = 3'd0;
               if (idx_q == 2'd3) begin
                  state_d = READ;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = VERIFY;
               end
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
`endif
         READ: begin
            if (!m_waitrequest) begin
               state_d = RWAIT;
               cnt_d   = 3'd0;
            end
         end
         RWAIT: begin
            if (lat_done) begin
               cnt_d   = 3'd0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus outputs are registered from the next state, so a stall simply recomputes the same values.
   always_comb begin
      wr_d    = (state_d == WRITE);
      rd_d    = (state_d == READ);
      addr_d  = 3'd0;
      wdata_d = 32'd0;
`ifdef SOBEL_HOST_READBACK_EN
      rd_d = rd_d || (state_d == VERIFY);
      if (state_d == VERIFY) addr_d = {1'b0, idx_d};
`endif
      if (wr_d) begin
         addr_d  = {1'b0, idx_d};
         wdata_d = accept_start ? row0 : row_q[idx_d];
      end else if (state_d == READ) begin
         addr_d = RESULT_ADDR;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= 2'd0;
         cnt_q        <= 3'd0;
         busy         <= 1'b0;
         done         <= 1'b0;
         result       <= 32'd0;
         m_addr       <= 3'd0;
         m_wdata      <= 32'd0;
         m_byteenable <= 4'h0;
         m_cs         <= 1'b0;
         m_read       <= 1'b0;
         m_write      <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         busy         <= (state_d != IDLE);
         done         <= (state_d == DONE);
         m_addr       <= addr_d;
         m_wdata      <= wdata_d;
         m_byteenable <= wr_d ? 4'hF : 4'h0;
         m_cs         <= wr_d | rd_d;
         m_read       <= rd_d;
         m_write      <= wr_d;
         if (state_q == RWAIT && lat_done) result <= m_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && accept_start) begin
         row_q[0] <= row0;
         row_q[1] <= row1;
         row_q[2] <= row2;
         row_q[3] <= row3;
      end
   end

`ifdef SOBEL_HOST_READBACK_EN
   logic mism_q, err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         mism_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (accept_start) begin
            mism_q <= 1'b0;
            err_q  <= 1'b0;
         end else if (state_q == VWAIT && lat_done && m_rdata != row_q[idx_q]) begin
            mism_q <= 1'b1;
         end
         if (state_d == DONE) err_q <= mism_q;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_sobel_host.sv
// Bench for sobel_host: two instances (READ_LATENCY 1 and 3) with behavioural Avalon agents.
module tb_sobel_host;
`ifdef SOBEL_HOST_READBACK_EN
   localparam int NRB = 4;
`else
   localparam int NRB = 0;
`endif

   logic clk = 1'b0;
   logic rst, start;
   logic [31:0] row0, row1, row2, row3;
   logic [1:0] busy, done, m_cs, m_read, m_write, err, m_waitrequest;
   logic [1:0][31:0] result, m_wdata, m_rdata;
   logic [1:0][2:0] m_addr;
   logic [1:0][3:0] m_byteenable;

   logic [31:0] exp_rows [4];
   logic [31:0] res_word;
   logic        corrupt;
   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : inst
      localparam int unsigned LAT = (g == 0) ? 1 : 3;
      logic [31:0] mem [4];
      logic        pend;
      logic [2:0]  left;
      logic [31:0] val;

      sobel_host #(.READ_LATENCY(LAT), .RESULT_ADDR(3'b100)) dut (
         .clk(clk), .rst(rst), .start(start),
         .row0(row0), .row1(row1), .row2(row2), .row3(row3),
         .busy(busy[g]), .done(done[g]), .result(result[g]),
         .m_addr(m_addr[g]), .m_wdata(m_wdata[g]), .m_byteenable(m_byteenable[g]),
         .m_cs(m_cs[g]), .m_read(m_read[g]), .m_write(m_write[g]),
         .m_waitrequest(m_waitrequest[g]), .m_rdata(m_rdata[g]), .err(err[g])
      );

      // Agent: memory for addr 0..3, result word at addr 4, data valid exactly LAT edges after acceptance.
      always @(posedge clk) begin
         if (rst) begin
            pend <= 1'b0;
         end else begin
            if (m_write[g] && !m_waitrequest[g]) mem[m_addr[g][1:0]] <= m_wdata[g];
            if (m_read[g] && !m_waitrequest[g]) begin
               pend <= 1'b1;
               left <= 3'(LAT - 1);
               if (m_addr[g] == 3'b100) val <= res_word;
               else if (m_addr[g] == 3'd1 && corrupt) val <= 32'h0000FFFE;
               else val <= mem[m_addr[g][1:0]];
            end else if (pend) begin
               if (left == 3'd0) pend <= 1'b0;
               else left <= left - 3'd1;
            end
         end
      end
      assign m_rdata[g] = (pend && left == 3'd0) ? val : 32'hA5A55A5A;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, expv);
   endtask

   function automatic int exp_done_t(int g, int stall);
      int lat;
      lat = (g == 0) ? 1 : 3;
      return 6 + lat + ((g == 0) ? stall : 0) + NRB * (1 + lat);
   endfunction

   function automatic int exp_wr_t(int g, int n, int stall);
      return n + 1 + ((g == 0 && n >= 2) ? stall : 0);
   endfunction

   task automatic drive_rows();
      row0 = exp_rows[0]; row1 = exp_rows[1]; row2 = exp_rows[2]; row3 = exp_rows[3];
   endtask

   task automatic run_tile(input string tag, input int stall, input bit mid_start, input bit exp_err);
      int wr_n [2];
      int rd_n [2];
      int dn_n [2];
      int dn_t [2];
      int bad  [2];
      logic [31:0] res [2];
      logic        er  [2];
      int          stall_left;
      logic        prev_wait;
      logic [2:0]  prev_addr;
      logic [31:0] prev_wdata;
      for (int g = 0; g < 2; g++) begin
         wr_n[g] = 0; rd_n[g] = 0; dn_n[g] = 0; dn_t[g] = -1; bad[g] = 0; res[g] = 'x; er[g] = 'x;
      end
      drive_rows();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      stall_left = stall;
      prev_wait  = 1'b0;
      prev_addr  = 3'd0;
      prev_wdata = 32'd0;
      for (int t = 1; t <= 40; t++) begin
         if (t > 1) @(negedge clk);
         m_waitrequest[0] = (stall_left > 0) && m_write[0] && (m_addr[0] == 3'd2);
         if (m_waitrequest[0]) stall_left--;
         if (mid_start && t == 3) begin
            start = 1'b1;
            row0 = ~exp_rows[0]; row1 = ~exp_rows[1]; row2 = ~exp_rows[2]; row3 = ~exp_rows[3];
         end
         if (mid_start && t == 4) start = 1'b0;
         if (prev_wait && (!m_write[0] || m_addr[0] != prev_addr || m_wdata[0] != prev_wdata)) bad[0]++;
         prev_wait = m_waitrequest[0]; prev_addr = m_addr[0]; prev_wdata = m_wdata[0];
         for (int g = 0; g < 2; g++) begin
            if (done[g]) begin
               dn_n[g]++; dn_t[g] = t; res[g] = result[g]; er[g] = err[g];
            end
            if (busy[g] != ((dn_n[g] == 0) || (dn_t[g] == t))) bad[g]++;
            if ((m_read[g] && m_write[g]) || (m_cs[g] != (m_read[g] | m_write[g]))) bad[g]++;
            if (m_write[g] && !m_waitrequest[g]) begin
               if (wr_n[g] > 3 || m_addr[g] != 3'(wr_n[g]) || m_byteenable[g] != 4'hF ||
                   m_wdata[g] != exp_rows[wr_n[g] & 3] || t != exp_wr_t(g, wr_n[g], stall)) bad[g]++;
               wr_n[g]++;
            end
            if (m_read[g] && !m_waitrequest[g]) begin
               if (m_addr[g] != ((rd_n[g] < NRB) ? 3'(rd_n[g]) : 3'b100)) bad[g]++;
               rd_n[g]++;
            end
         end
      end
      m_waitrequest = 2'b00;
      for (int g = 0; g < 2; g++) begin
         check($sformatf("%s.writes%0d", tag, g), wr_n[g], 4);
         check($sformatf("%s.reads%0d", tag, g), rd_n[g], NRB + 1);
         check($sformatf("%s.done_cnt%0d", tag, g), dn_n[g], 1);
         check($sformatf("%s.done_t%0d", tag, g), dn_t[g], exp_done_t(g, stall));
         check($sformatf("%s.result%0d", tag, g), res[g], res_word);
         check($sformatf("%s.protocol%0d", tag, g), bad[g], 0);
`ifdef SOBEL_HOST_READBACK_EN
         check($sformatf("%s.err%0d", tag, g), er[g], exp_err);
`endif
      end
      if (stall > 0) check({tag, ".stall_used"}, stall_left, 0);
   endtask

   task automatic rand_rows();
      for (int i = 0; i < 4; i++) exp_rows[i] = $urandom;
   endtask

   initial begin
      int dn;
      rst = 1'b1; start = 1'b1; m_waitrequest = 2'b00; res_word = 32'd0; corrupt = 1'b0;
      for (int i = 0; i < 4; i++) exp_rows[i] = 32'd0;
      drive_rows();
      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         check($sformatf("rst.busy%0d", g), busy[g], 0);
         check($sformatf("rst.done%0d", g), done[g], 0);
         check($sformatf("rst.strobes%0d", g), {m_cs[g], m_read[g], m_write[g]}, 0);
         check($sformatf("rst.addr%0d", g), m_addr[g], 0);
         check($sformatf("rst.wdata%0d", g), m_wdata[g], 0);
         check($sformatf("rst.be%0d", g), m_byteenable[g], 0);
         check($sformatf("rst.result%0d", g), result[g], 0);
         check($sformatf("rst.err%0d", g), err[g], 0);
      end
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check("rst_start.busy0", busy[0], 0);
      check("rst_start.busy1", busy[1], 0);

      for (int i = 0; i < 4; i++) exp_rows[i] = 32'h0000FFFF;
      res_word = 32'h00FFFF00;
      run_tile("basic", 0, 1'b0, 1'b0);

      rand_rows(); res_word = 32'hDEADBEEF;
      run_tile("latency", 0, 1'b0, 1'b0);

      rand_rows(); res_word = $urandom;
      run_tile("stall", 3, 1'b0, 1'b0);

      for (int i = 0; i < 3; i++) begin
         rand_rows(); res_word = $urandom;
         run_tile($sformatf("rand%0d", i), int'($urandom_range(0, 2)), 1'b0, 1'b0);
      end

      rand_rows(); res_word = $urandom;
      run_tile("busy_start", 0, 1'b1, 1'b0);

      rand_rows(); drive_rows();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      check("abort.addr1", m_addr[0], 1);
      check("abort.write", m_write[0], 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int g = 0; g < 2; g++) begin
         check($sformatf("abort.strobes%0d", g), {m_cs[g], m_read[g], m_write[g]}, 0);
         check($sformatf("abort.busy%0d", g), busy[g], 0);
         check($sformatf("abort.result%0d", g), result[g], 0);
      end
      dn = 0;
      repeat (12) begin
         @(negedge clk);
         if (done != 2'b00) dn++;
      end
      check("abort.no_done", dn, 0);

      rand_rows(); res_word = $urandom;
      run_tile("post_abort", 0, 1'b0, 1'b0);

`ifdef SOBEL_HOST_READBACK_EN
      for (int i = 0; i < 4; i++) exp_rows[i] = 32'h0000FFFF;
      res_word = 32'h00FFFF00;
      corrupt = 1'b1;
      run_tile("rb_corrupt", 0, 1'b0, 1'b1);
      corrupt = 1'b0;
      run_tile("rb_clean", 0, 1'b0, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
